// File: rtl/matrix_3x3_gen.sv
// Streaming 3x3 window generator: uses two external FIFOs as row delays and
// emits one registered window per interior pixel, two cycles after its accept.
module matrix_3x3_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_sof,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  lb0_wr_en,
   output logic [DATA_WIDTH-1:0] lb0_wr_data,
   output logic                  lb0_rd_en,
   input  logic [DATA_WIDTH-1:0] lb0_rd_data,
   output logic                  lb1_wr_en,
   output logic [DATA_WIDTH-1:0] lb1_wr_data,
   output logic                  lb1_rd_en,
   input  logic [DATA_WIDTH-1:0] lb1_rd_data,
   output logic                  lb_clr,
   output logic [DATA_WIDTH-1:0] m11,
   output logic [DATA_WIDTH-1:0] m12,
   output logic [DATA_WIDTH-1:0] m13,
   output logic [DATA_WIDTH-1:0] m21,
   output logic [DATA_WIDTH-1:0] m22,
   output logic [DATA_WIDTH-1:0] m23,
   output logic [DATA_WIDTH-1:0] m31,
   output logic [DATA_WIDTH-1:0] m32,
   output logic [DATA_WIDTH-1:0] m33,
   output logic                  out_valid,
   output logic                  out_last,
   output logic                  err
);

   // state | meaning
   // IDLE  | waiting for in_sof; in_sof dropped while lb_clr is high
   // RUN   | accepting pixels of the current frame
   // FLUSH | one cycle after the last pixel; schedules lb_clr
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   state_t state, state_n;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic accept, abort, sof_drop, at_end, at_origin;
   logic rst_q;
   logic acc_q, mid_en_q, top_en_q, win_q, last_q;
   logic [DATA_WIDTH-1:0] data_q, col_mid, col_top;

   assign at_end    = (col == COL_LAST) && (row == ROW_LAST);
   assign at_origin = (col == '0) && (row == '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      abort    = 1'b0;
      sof_drop = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_sof) begin
               if (lb_clr) begin
                  sof_drop = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            if (in_valid) begin
               if (in_sof && !at_origin) begin
                  abort   = 1'b1;
                  state_n = IDLE;
               end else begin
                  accept = 1'b1;
                  if (at_end) state_n = FLUSH;
               end
            end
         end
         FLUSH: begin
            state_n = IDLE;
            if (in_valid && in_sof) sof_drop = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (rst) begin
         accept   = 1'b0;
         abort    = 1'b0;
         sof_drop = 1'b0;
      end
   end

   // Counters hold the position of the next pixel; they return to 0 whenever
   // the FSM goes back to IDLE, so the sof pixel is always (0,0).
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= at_end ? '0 : row + ROW_ONE;
         end else begin
            col <= col + COL_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         err    <= 1'b0;
         lb_clr <= 1'b1;
      end else begin
         err    <= abort | sof_drop;
         lb_clr <= rst_q | abort | (state == FLUSH);
      end
   end

   assign lb0_wr_en   = accept;
   assign lb0_wr_data = accept ? in_data : '0;
   assign lb0_rd_en   = accept && (row != '0);
   assign lb1_rd_en   = accept && (row > ROW_ONE);
   assign lb1_wr_en   = acc_q && mid_en_q;
   assign lb1_wr_data = lb1_wr_en ? lb0_rd_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= 1'b0;
         mid_en_q <= 1'b0;
         top_en_q <= 1'b0;
         win_q    <= 1'b0;
         last_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         acc_q <= accept;
         if (accept) begin
            data_q   <= in_data;
            mid_en_q <= (row != '0);
            top_en_q <= (row > ROW_ONE);
            win_q    <= (row > ROW_ONE) && (col > COL_ONE);
            last_q   <= at_end;
         end
      end
   end

   // Rows that do not exist yet are forced to zero so stale FIFO data never
   // reaches the window registers.
   assign col_mid = mid_en_q ? lb0_rd_data : '0;
   assign col_top = top_en_q ? lb1_rd_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         {m11, m12, m13, m21, m22, m23, m31, m32, m33} <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= acc_q & win_q;
         out_last  <= acc_q & win_q & last_q;
         if (acc_q) begin
            m11 <= m12;
            m12 <= m13;
            m13 <= col_top;
            m21 <= m22;
            m22 <= m23;
            m23 <= col_mid;
            m31 <= m32;
            m32 <= m33;
            m33 <= data_q;
         end
      end
   end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: behavioural line-buffer FIFOs plus a window
// scoreboard filled as pixels are driven and drained as windows appear.
module tb_matrix_3x3_gen;
   localparam int DW   = 8;
   localparam int W    = 5;
   localparam int H    = 4;
   localparam int NWIN = (W - 2) * (H - 2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en, lb_clr;
   logic [DW-1:0] lb0_wr_data, lb1_wr_data;
   logic [DW-1:0] lb0_rd_data = '0;
   logic [DW-1:0] lb1_rd_data = '0;
   logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
   logic          out_valid, out_last, err;

   matrix_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .lb0_wr_en(lb0_wr_en), .lb0_wr_data(lb0_wr_data), .lb0_rd_en(lb0_rd_en),
      .lb0_rd_data(lb0_rd_data), .lb1_wr_en(lb1_wr_en), .lb1_wr_data(lb1_wr_data),
      .lb1_rd_en(lb1_rd_en), .lb1_rd_data(lb1_rd_data), .lb_clr(lb_clr),
      .m11(m11), .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23),
      .m31(m31), .m32(m32), .m33(m33),
      .out_valid(out_valid), .out_last(out_last), .err(err)
   );

   wire [71:0] obs_win = {m11, m12, m13, m21, m22, m23, m31, m32, m33};
   wire [94:0] all_out = {lb0_wr_en, lb0_wr_data, lb0_rd_en, lb1_wr_en, lb1_wr_data,
                          lb1_rd_en, obs_win, out_valid, out_last, err};

   // Line-buffer FIFOs with one-cycle read latency.
   logic [DW-1:0] fq0[$];
   logic [DW-1:0] fq1[$];
   int underflows = 0;
   always @(posedge clk) begin
      if (lb_clr) begin
         fq0.delete();
         fq1.delete();
      end else begin
         if (lb0_rd_en) begin
            if (fq0.size() == 0) underflows = underflows + 1;
            else lb0_rd_data <= fq0.pop_front();
         end
         if (lb0_wr_en) fq0.push_back(lb0_wr_data);
         if (lb1_rd_en) begin
            if (fq1.size() == 0) underflows = underflows + 1;
            else lb1_rd_data <= fq1.pop_front();
         end
         if (lb1_wr_en) fq1.push_back(lb1_wr_data);
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [71:0] win;
      logic        last;
      int          due;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad = 0;
   int win_cnt = 0;
   logic [71:0] first_win = '0;
   logic [7:0]  last_m33 = '0;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (out_valid) begin
         win_cnt++;
         if (win_cnt == 1) first_win = obs_win;
         if (out_last) last_m33 = m33;
         if (sb.size() == 0) begin
            chk("unexpected_valid", 96'(out_valid), 96'(0));
         end else begin
            e = sb.pop_front();
            chk("window", 96'(obs_win), 96'(e.win));
            chk("out_last", 96'(out_last), 96'(e.last));
            chk("latency", 96'(cyc), 96'(e.due));
         end
      end else begin
         chk("last_without_valid", 96'(out_last), 96'(0));
         if (sb.size() > 0) chk("window_late", 96'(cyc > sb[0].due), 96'(0));
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sof   = s;
      in_data  = d;
   endtask

   task automatic sample(input logic exp_wr);
      @(negedge clk);
      chk("lb0_wr_en", 96'(lb0_wr_en), 96'(exp_wr));
      monitor();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, DW'($urandom));
      sample(1'b0);
   endtask

   task automatic reset_release();
      drive(1'b0, 1'b0, '0);
      rst = 1'b0;
      sample(1'b0);
      idle();
      chk("lb_clr_after_release", 96'(lb_clr), 96'(1));
      idle();
      chk("lb_clr_released", 96'(lb_clr), 96'(0));
   endtask

   task automatic frame(input logic [7:0] base, input int gap_pct,
                        input int abort_r, input int abort_c,
                        input int rst_r, input int rst_c, input bit flush_sof);
      logic [7:0] img [H][W];
      logic [7:0] pix;
      exp_t e;
      win_cnt  = 0;
      last_m33 = '0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) repeat ($urandom_range(1, 3)) idle();
            pix = base + 8'(16 * r + c);
            if (r == abort_r && c == abort_c) begin
               drive(1'b1, 1'b1, pix);
               sample(1'b0);
               idle();
               chk("abort_err", 96'(err), 96'(1));
               chk("abort_lb_clr", 96'(lb_clr), 96'(1));
               idle();
               chk("abort_err_end", 96'(err), 96'(0));
               chk("abort_lb_clr_end", 96'(lb_clr), 96'(0));
               return;
            end
            if (r == rst_r && c == rst_c) begin
               sb.delete();
               drive(1'b1, 1'b0, pix);
               rst = 1'b1;
               sample(1'b0);
               drive(1'b1, 1'b0, pix);
               sample(1'b0);
               chk("midrst_outputs", 96'(all_out), 96'(0));
               chk("midrst_lb_clr", 96'(lb_clr), 96'(1));
               reset_release();
               return;
            end
            img[r][c] = pix;
            drive(1'b1, (r == 0 && c == 0), pix);
            if (r >= 2 && c >= 2) begin
               e.win  = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                         img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                         img[r][c-2],   img[r][c-1],   img[r][c]};
               e.last = (r == H - 1) && (c == W - 1);
               e.due  = cyc + 2;
               sb.push_back(e);
            end
            sample(1'b1);
         end
      end
      if (flush_sof) begin
         drive(1'b1, 1'b1, 8'hEE);
         sample(1'b0);
      end else begin
         idle();
      end
      chk("flush_lb_clr", 96'(lb_clr), 96'(0));
      chk("flush_err", 96'(err), 96'(0));
      idle();
      chk("eof_lb_clr", 96'(lb_clr), 96'(1));
      chk("eof_err", 96'(err), 96'(flush_sof));
      chk("window_count", 96'(win_cnt), 96'(NWIN));
      chk("first_m11", 96'(first_win[71:64]), 96'(base));
      chk("last_m33", 96'(last_m33), 96'(base + 8'h34));
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) begin
         drive(1'b1, 1'b0, 8'h5A);
         sample(1'b0);
      end
      chk("reset_outputs", 96'(all_out), 96'(0));
      chk("reset_lb_clr", 96'(lb_clr), 96'(1));
      reset_release();

      repeat (3) begin
         drive(1'b1, 1'b0, 8'h33);
         sample(1'b0);
      end
      idle();

      frame(8'h00, 0, -1, -1, -1, -1, 1'b0);
      chk("basic_first_window", 96'(first_win), 96'(72'h00_01_02_10_11_12_20_21_22));
      frame(8'h00, 50, -1, -1, -1, -1, 1'b0);
      frame(8'h80, 0, -1, -1, -1, -1, 1'b0);

      frame(8'h40, 0, 1, 2, -1, -1, 1'b0);
      repeat (4) idle();
      frame(8'h10, 0, -1, -1, -1, -1, 1'b0);

      frame(8'h20, 0, -1, -1, -1, -1, 1'b1);
      frame(8'h00, 30, -1, -1, -1, -1, 1'b0);

      frame(8'h00, 0, -1, -1, 2, 3, 1'b0);
      frame(8'h60, 0, -1, -1, -1, -1, 1'b0);

      repeat (3) idle();
      chk("scoreboard_empty", 96'(sb.size()), 96'(0));
      chk("fifo_underflow", 96'(underflows), 96'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
